tone_period_meter: RTL and testbench

- Receive-side counterpart of the tone divider: measures the period of an incoming square-wave tone in clk cycles and reports it as a divisor-style number.
- Sits between a tone source (external pin, or the divider's output in loopback self-test) and the note-recognition/display logic.
- Also detects silence (no edges) and a stable "locked" pitch.

---
 rtl/tone_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/tone_period_meter.sv | 156 +++++++++++++++
 tb/tb_tone_period_meter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tone_pkg
// Brief   : Shared types and default constants for the tone divider/meter.
// Revision: 1.0 - initial release
// ============================================================================
package tone_pkg;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_TIMEOUT     = 2000000;  // 20 ms at 100 MHz
  localparam int unsigned DEF_MATCH_TOL   = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef logic [DEF_CNT_W-1:0] period_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_det
// Brief   : Multi-flop synchroniser for an asynchronous input plus a
//           one-cycle rising-edge pulse on the synchronised level.
// Revision: 1.0 - initial release
// ============================================================================
module sync_edge_det
  import tone_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/tone_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : tone_period_meter
// Brief   : Measures the period of a square-wave tone in clk cycles, flags
//           silence and a locked pitch. Define PERIOD_AVG_EN to report the
//           average of the last four raw periods instead of the raw period.
// Revision: 1.0 - initial release
// ============================================================================
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned MATCH_TOL   = DEF_MATCH_TOL,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             silent
);

  localparam logic [CNT_W-1:0] c_TIMEOUT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_MATCH_TOL = CNT_W'(MATCH_TOL);

  logic             w_rise;
  logic             w_tone_sync;
  logic             w_rise_q;
  meter_state_t     r_state;
  meter_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_prev;
  logic             r_prev_vld;
  logic             w_edge;
  logic             w_timeout;
  logic [CNT_W-1:0] w_diff;
  logic             w_match;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(tone_in),
    .sync_out(w_tone_sync),
    .rise    (w_rise)
  );

  assign w_rise_q  = w_rise & w_tone_sync;
  assign w_edge    = (r_state == MEASURE) && w_rise_q;
  // An edge on the TIMEOUT cycle wins and is published as a normal period.
  assign w_timeout = (r_state == MEASURE) && !w_rise_q && (r_count == c_TIMEOUT);
  assign w_diff    = (r_count >= r_prev) ? (r_count - r_prev) : (r_prev - r_count);
  assign w_match   = r_prev_vld && (w_diff <= c_MATCH_TOL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise_q)  w_state_nxt = MEASURE;
      MEASURE: if (w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      locked     <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_rise_q) r_count <= CNT_W'(1);
    end else if (w_rise_q) begin
      r_count    <= CNT_W'(1);
      r_prev     <= r_count;
      r_prev_vld <= 1'b1;
      locked     <= w_match;
    end else if (w_timeout) begin
      r_count    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef PERIOD_AVG_EN
  // Three older raw periods plus the one closing now form the 4-entry window.
  logic [CNT_W-1:0] r_hist [3];
  logic [1:0]       r_fill;
  logic [CNT_W+1:0] w_sum;

  assign w_sum = {2'b00, r_count} + {2'b00, r_hist[0]}
               + {2'b00, r_hist[1]} + {2'b00, r_hist[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
      r_fill       <= '0;
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
    end else begin
      period_valid <= 1'b0;
      if (w_edge) begin
        r_hist[0] <= r_count;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
        if (r_fill == 2'd3) begin
          period       <= w_sum[CNT_W+1:2];
          period_valid <= 1'b1;
          silent       <= 1'b0;
        end else begin
          r_fill <= r_fill + 2'd1;
        end
      end else if (w_timeout) begin
        period       <= '0;
        period_valid <= 1'b1;
        silent       <= 1'b1;
        r_fill       <= '0;
        for (int i = 0; i < 3; i++) r_hist[i] <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      if (w_edge) begin
        period       <= r_count;
        period_valid <= 1'b1;
        silent       <= 1'b0;
      end else if (w_timeout) begin
        period       <= '0;
        period_valid <= 1'b1;
        silent       <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tone_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tone_period_meter
// Brief   : Scoreboard bench for tone_period_meter with a rise-time based
//           reference model; honours PERIOD_AVG_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tone_period_meter;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 4;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 1;  // drive-to-publish latency in cycles

  logic             clk = 1'b0;
  logic             rst;
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             silent;

  tone_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .MATCH_TOL  (TOL),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .silent      (silent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             silent;
    int               at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: rise times as seen at tone_in
  bit   meas     = 0;
  bit   prev_ok  = 0;
  int   prev_raw = 0;
  int   last_rise = 0;
  int   hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && period_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got period=%0d at cycle %0d, expected no publish", period, cyc);
      end else begin
        m_e = sb.pop_front();
        chk("period",        64'(period), 64'(m_e.period));
        chk("locked",        64'(locked), 64'(m_e.locked));
        chk("silent",        64'(silent), 64'(m_e.silent));
        chk("publish_cycle", 64'(cyc),    64'(m_e.at));
      end
    end
  end

  task automatic model_raw(input int raw, input int at);
    exp_t e;
    int   d;
    int   sum;
    d = (raw > prev_raw) ? raw - prev_raw : prev_raw - raw;
    e.locked = prev_ok && (d <= TOL);
    e.silent = 1'b0;
    e.at     = at;
`ifdef PERIOD_AVG_EN
    hist.push_back(raw);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4) begin
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      e.period = CNT_W'(sum / 4);
      sb.push_back(e);
    end
`else
    sum = raw;
    e.period = CNT_W'(sum);
    sb.push_back(e);
`endif
    prev_raw = raw;
    prev_ok  = 1;
  endtask

  task automatic model_rise();
    if (meas) model_raw(cyc - last_rise, cyc + LAT);
    else meas = 1;
    last_rise = cyc;
  endtask

  // Declares the current gap will exceed TIMEOUT: the meter times out.
  task automatic go_silent();
    exp_t e;
    if (meas) begin
      e.period = '0;
      e.locked = 1'b0;
      e.silent = 1'b1;
      e.at     = last_rise + LAT + TIMEOUT;
      sb.push_back(e);
    end
    meas    = 0;
    prev_ok = 0;
    hist.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int h);
    tone_in = 1'b1;
    model_rise();
    if (p > TIMEOUT) go_silent();
    tick(h);
    tone_in = 1'b0;
    tick(p - h);
  endtask

  task automatic do_reset(input int n, input bit toggle);
    chk("sb_empty_at_reset", 64'(sb.size()), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (toggle) tone_in = ~tone_in;
      @(negedge clk);
      chk("rst_period", 64'(period),       64'd0);
      chk("rst_valid",  64'(period_valid), 64'd0);
      chk("rst_locked", 64'(locked),       64'd0);
      chk("rst_silent", 64'(silent),       64'd1);
    end
    tone_in = 1'b0;
    sb.delete();
    meas    = 0;
    prev_ok = 0;
    hist.delete();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int p;
    int h;
    int n;
    rst     = 1'b1;
    tone_in = 1'b0;
    @(negedge clk);
    do_reset(4, 1'b1);
    tick(3);

    // 5 high / 5 low, then pitch change 10 -> 20 -> 22
    repeat (6) drive_period(10, 5);
    repeat (3) drive_period(20, 10);
    repeat (2) drive_period(22, 11);
    repeat (3) drive_period(10, 5);

    // Silence, then restart: first edge after IDLE does not publish
    go_silent();
    tick(TIMEOUT + 20);
    repeat (3) drive_period(10, 5);

    // Period exactly TIMEOUT is published; TIMEOUT+1 times out
    drive_period(TIMEOUT, 5);
    drive_period(TIMEOUT, 5);
    drive_period(TIMEOUT + 1, 5);
    repeat (3) drive_period(10, 5);

    // Reset 4 cycles after an edge while mid-measurement
    repeat (3) drive_period(10, 3);
    tone_in = 1'b1;
    model_rise();
    tick(3);
    tone_in = 1'b0;
    tick(1);
    do_reset(4, 1'b0);
    tick(2);
    repeat (3) drive_period(10, 5);

    // Averaging reference sequence 10,10,20,20,20
    go_silent();
    tick(TIMEOUT + 20);
    drive_period(10, 5);
    drive_period(10, 5);
    drive_period(20, 10);
    drive_period(20, 10);
    drive_period(20, 10);
    drive_period(20, 10);

    // Randomised pitches with jitter, occasional long periods and silences
    for (int k = 0; k < 40; k++) begin
      base = int'($urandom_range(2, 60));
      n    = int'($urandom_range(2, 6));
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) p = int'($urandom_range(TIMEOUT - 5, TIMEOUT + 6));
        else p = base + int'($urandom_range(0, 10)) - 5;
        if (p < 2) p = 2;
        h = int'($urandom_range(1, p - 1));
        drive_period(p, h);
      end
      if ($urandom_range(0, 9) == 0) begin
        go_silent();
        tick(TIMEOUT + int'($urandom_range(5, 30)));
      end
    end

    go_silent();
    tick(TIMEOUT + 20);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
